noc_output_port: RTL and testbench

- Output stage of a router port, directly downstream of the per-input packet FIFOs.
- Each cycle it round-robin selects one non-empty input FIFO, pops one packet from it and registers that packet onto the outgoing link.
- Link flow control is credit-based: one credit per free slot in the neighbour router's input FIFO, returned one at a time by credit_in pulses.
- A packet_t (noc_params) is treated as an atomic unit; there is no multi-flit/wormhole locking.

---
 rtl/noc_output_port.sv | 132 +++++++++++++
 tb/tb_noc_output_port.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/noc_output_port.sv
// Output stage of a router port: round-robin arbitration over the input
// FIFOs, one registered packet per cycle onto the link, credit-based flow
// control toward the downstream router's input FIFO.

package noc_params;
    parameter int PKT_WIDTH = 32;
    typedef logic [PKT_WIDTH-1:0] packet_t;
endpackage

module noc_output_port
    import noc_params::*;
#(
    parameter int NUM_INPUTS = 5,
    parameter int CREDITS    = 16,
    parameter int CRED_WIDTH = $clog2(CREDITS + 1),
    parameter int IDX_WIDTH  = $clog2(NUM_INPUTS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_INPUTS-1:0] in_empty,
    input  packet_t               in_data [NUM_INPUTS],
    output logic [NUM_INPUTS-1:0] in_rd_en,
    output logic                  out_valid,
    output packet_t               out_data,
    input  logic                  credit_in,
    output logic [CRED_WIDTH-1:0] credit_count,
    output logic [IDX_WIDTH-1:0]  grant_idx,
    output logic                  credit_err
);

    localparam logic [CRED_WIDTH-1:0] CREDITS_MAX = CRED_WIDTH'(CREDITS);
    localparam logic [IDX_WIDTH:0]    NUM_WIDE    = (IDX_WIDTH + 1)'(NUM_INPUTS);
    localparam logic [IDX_WIDTH-1:0]  LAST_IDX    = IDX_WIDTH'(NUM_INPUTS - 1);

    // State registers and their next-state values
    logic                  out_valid_q, out_valid_d;
    packet_t               out_data_q,  out_data_d;
    logic [CRED_WIDTH-1:0] credit_q,    credit_d;
    logic [IDX_WIDTH-1:0]  grant_idx_q, grant_idx_d;
    logic [IDX_WIDTH-1:0]  rr_ptr_q,    rr_ptr_d;
    logic                  credit_err_q, credit_err_d;

    // Arbitration signals
    logic [NUM_INPUTS-1:0] req;
    logic                  send;
    logic [IDX_WIDTH-1:0]  grant;
    logic                  grant_found;
    logic [IDX_WIDTH:0]    probe;

    assign req  = ~in_empty;
    // A pop needs a requester, a free downstream slot, and no reset in progress.
    assign send = !rst && (credit_q != '0) && (|req);

    // Round-robin search: first requester at or after rr_ptr, wrapping around.
    always_comb begin
        grant       = '0;
        grant_found = 1'b0;
        probe       = '0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            probe = {1'b0, rr_ptr_q} + (IDX_WIDTH + 1)'(k);
            if (probe >= NUM_WIDE) begin
                probe = probe - NUM_WIDE;
            end
            if (!grant_found && req[probe[IDX_WIDTH-1:0]]) begin
                grant       = probe[IDX_WIDTH-1:0];
                grant_found = 1'b1;
            end
        end
    end

    // One-hot pop strobe; only ever raised on a requesting (non-empty) input.
    generate
        for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_rd_en
            assign in_rd_en[gi] = send && (grant == IDX_WIDTH'(gi));
        end
    endgenerate

    // Link register and arbitration pointer next state.
    always_comb begin
        out_valid_d = send;
        out_data_d  = out_data_q;
        grant_idx_d = grant_idx_q;
        rr_ptr_d    = rr_ptr_q;
        if (send) begin
            out_data_d  = in_data[grant];
            grant_idx_d = grant;
            rr_ptr_d    = (grant == LAST_IDX) ? '0 : grant + IDX_WIDTH'(1);
        end
    end

    // Credit counter: -1 per send, +1 per returned credit, saturating at
    // CREDITS with a sticky error flag when the neighbour over-returns.
    always_comb begin
        credit_d     = credit_q;
        credit_err_d = credit_err_q;
        if (send && !credit_in) begin
            credit_d = credit_q - CRED_WIDTH'(1);
        end else if (!send && credit_in) begin
            if (credit_q == CREDITS_MAX) begin
                credit_err_d = 1'b1;
            end else begin
                credit_d = credit_q + CRED_WIDTH'(1);
            end
        end
    end

    // State update with synchronous reset; reset drops any in-flight packet.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            credit_q     <= CREDITS_MAX;
            grant_idx_q  <= '0;
            rr_ptr_q     <= '0;
            credit_err_q <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            credit_q     <= credit_d;
            grant_idx_q  <= grant_idx_d;
            rr_ptr_q     <= rr_ptr_d;
            credit_err_q <= credit_err_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign credit_count = credit_q;
    assign grant_idx    = grant_idx_q;
    assign credit_err   = credit_err_q;

endmodule

// File: tb/tb_noc_output_port.sv
// Testbench for noc_output_port: bench-side FIFO queues feed the DUT, a
// reference model predicts grants/credits, and a scoreboard queue holds
// expected packets until they appear on the link.

module tb_noc_output_port;
    import noc_params::*;

    localparam int N  = 5;
    localparam int CR = 16;

    logic         clk;
    logic         rst;
    logic [N-1:0] in_empty;
    packet_t      in_data [N];
    logic [N-1:0] in_rd_en;
    logic         out_valid;
    packet_t      out_data;
    logic         credit_in;
    logic [4:0]   credit_count;
    logic [2:0]   grant_idx;
    logic         credit_err;

    noc_output_port #(
        .NUM_INPUTS(N),
        .CREDITS   (CR)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_empty    (in_empty),
        .in_data     (in_data),
        .in_rd_en    (in_rd_en),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .credit_in   (credit_in),
        .credit_count(credit_count),
        .grant_idx   (grant_idx),
        .credit_err  (credit_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Bench-side input FIFOs and scoreboard of expected {grant, data}
    logic [31:0] fifo_q [N][$];
    logic [35:0] sb_q [$];

    // Reference model state
    int  m_cred;
    int  m_rr;
    int  m_gidx;
    bit  m_err;
    bit  exp_valid;

    int  checks_cnt;
    int  fail_cnt;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive at the falling edge, check the combinational pop
    // strobe, advance the model, then check registered outputs at the next
    // falling edge.
    task automatic step(input bit c_in, input bit r);
        bit          send;
        bit          found;
        int          g;
        int          idx;
        logic [N-1:0] exp_rd;
        logic [35:0] e;
        for (int i = 0; i < N; i++) begin
            in_empty[i] = (fifo_q[i].size() == 0);
            in_data[i]  = in_empty[i] ? 32'h0 : fifo_q[i][0];
        end
        credit_in = c_in;
        rst       = r;
        #1;
        send  = !r && (m_cred != 0) && (in_empty != '1);
        g     = 0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = (m_rr + k) % N;
            if (!found && !in_empty[idx]) begin
                g     = idx;
                found = 1'b1;
            end
        end
        exp_rd = send ? (N'(1) << g) : '0;
        check("rd_en", in_rd_en, exp_rd);
        if (r) begin
            m_cred    = CR;
            m_err     = 1'b0;
            m_rr      = 0;
            m_gidx    = 0;
            exp_valid = 1'b0;
            sb_q.delete();
        end else begin
            if (send) begin
                sb_q.push_back({4'(g), fifo_q[g][0]});
                void'(fifo_q[g].pop_front());
                m_gidx = g;
                m_rr   = (g == N - 1) ? 0 : g + 1;
            end
            if (send && !c_in) begin
                m_cred--;
            end else if (!send && c_in) begin
                if (m_cred == CR) m_err = 1'b1;
                else              m_cred++;
            end
            exp_valid = send;
        end
        @(negedge clk);
        check("out_valid", out_valid, exp_valid);
        if (out_valid) begin
            if (sb_q.size() == 0) begin
                check("spurious_valid", out_valid, 1'b0);
            end else begin
                e = sb_q.pop_front();
                check("out_data", out_data, e[31:0]);
                check("sb_grant", grant_idx, e[35:32]);
            end
        end
        check("grant_idx", grant_idx, m_gidx);
        check("credit_count", credit_count, m_cred);
        check("credit_err", credit_err, m_err);
        $display("cycle t=%0t rst=%0b cin=%0b rd_en=%b valid=%0b data=%08h gidx=%0d cred=%0d err=%0b",
                 $time, r, c_in, in_rd_en, out_valid, out_data, grant_idx, credit_count, credit_err);
    endtask

    task automatic clear_fifos();
        for (int i = 0; i < N; i++) fifo_q[i].delete();
    endtask

    initial begin
        checks_cnt = 0;
        fail_cnt   = 0;
        m_cred     = CR;
        m_rr       = 0;
        m_gidx     = 0;
        m_err      = 1'b0;
        exp_valid  = 1'b0;
        rst        = 1'b1;
        credit_in  = 1'b0;
        in_empty   = '1;
        for (int i = 0; i < N; i++) in_data[i] = '0;

        // Reset, then idle with all FIFOs empty
        step(0, 1);
        step(0, 1);
        for (int c = 0; c < 10; c++) step(0, 0);

        // Single packet on input 2
        fifo_q[2].push_back(32'hA5);
        step(0, 0);
        step(0, 0);
        check("cred_after_one", credit_count, 5'd15);

        // All inputs busy, no credit returns: 16 pops then stall
        step(0, 1);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < 5; j++) fifo_q[i].push_back(32'h1000 + i * 16 + j);
        for (int c = 0; c < 19; c++) step(0, 0);
        check("cred_exhausted", credit_count, 5'd0);

        // Credits at zero, input 1 waiting, one credit returned
        clear_fifos();
        fifo_q[1].push_back(32'hBEEF0001);
        step(1, 0);
        check("cred_one", credit_count, 5'd1);
        step(0, 0);
        step(0, 0);
        check("cred_zero_again", credit_count, 5'd0);

        // Send and credit together at 7, then overflow at full
        clear_fifos();
        step(0, 1);
        for (int j = 0; j < 9; j++) fifo_q[0].push_back(32'h7000 + j);
        for (int c = 0; c < 9; c++) step(0, 0);
        fifo_q[0].push_back(32'h7777);
        step(1, 0);
        check("cred_hold7", credit_count, 5'd7);
        for (int c = 0; c < 9; c++) step(1, 0);
        step(1, 0);
        check("cred_sat", credit_count, 5'd16);
        for (int c = 0; c < 3; c++) step(0, 0);
        check("err_sticky", credit_err, 1'b1);

        // Reset while streaming from inputs 3 and 4
        for (int j = 0; j < 6; j++) begin
            fifo_q[3].push_back(32'h3000 + j);
            fifo_q[4].push_back(32'h4000 + j);
        end
        for (int c = 0; c < 3; c++) step(0, 0);
        step(0, 1);
        check("err_cleared", credit_err, 1'b0);
        step(0, 0);
        check("first_after_rst", grant_idx, 3'd3);

        // Random traffic with credit returns
        clear_fifos();
        step(0, 1);
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 3) == 0 && fifo_q[i].size() < 4)
                    fifo_q[i].push_back($urandom);
            step((m_cred < CR) && ($urandom_range(0, 2) != 0), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule
